// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module   : gshare_predictor
// Brief    : Gshare conditional-branch direction predictor (PC xor global
//            history into a table of saturating counters, with mispredict
//            recovery of the speculative history).
// Revision : 1.0 - initial release
// ============================================================================
module gshare_predictor #(
    parameter int PC_WIDTH  = 32,
    parameter int PHT_WIDTH = 6,
    parameter int GHR_WIDTH = 6,
    parameter int CTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    input  logic [PC_WIDTH-1:0]  lookup_pc,
    output logic                 pred_taken,
    output logic [PHT_WIDTH-1:0] pred_index,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 update_valid,
    input  logic [PHT_WIDTH-1:0] update_index,
    input  logic                 update_taken,
    input  logic                 update_mispredict,
    input  logic [GHR_WIDTH-1:0] update_ghr,
    output logic [31:0]          mispredict_count
);

    localparam int                   c_pht_size = 1 << PHT_WIDTH;
    localparam logic [CTR_WIDTH-1:0] c_ctr_init = {1'b0, {(CTR_WIDTH-1){1'b1}}};
    localparam logic [CTR_WIDTH-1:0] c_ctr_max  = '1;

    logic [CTR_WIDTH-1:0] r_pht [c_pht_size];
    logic [GHR_WIDTH-1:0] r_ghr;
    logic [31:0]          r_mispredict_count;

    logic [PHT_WIDTH-1:0] w_hist_ext;
    logic [PHT_WIDTH-1:0] w_index;
    logic [GHR_WIDTH-1:0] w_ghr_shift;
    logic [GHR_WIDTH-1:0] w_ghr_recover;
    logic                 w_recover;
    logic                 w_unused_bits;

    generate
        if (GHR_WIDTH == PHT_WIDTH) begin : g_hist_full
            assign w_hist_ext = r_ghr;
        end else begin : g_hist_pad
            assign w_hist_ext = {{(PHT_WIDTH-GHR_WIDTH){1'b0}}, r_ghr};
        end
    endgenerate

    // Word-aligned PC bits hashed with history; the slice width makes the wrap implicit.
    assign w_index    = lookup_pc[PHT_WIDTH+1:2] ^ w_hist_ext;
    assign pred_index = w_index;
    assign pred_taken = r_pht[w_index][CTR_WIDTH-1];
    assign pred_ghr   = r_ghr;

    assign mispredict_count = r_mispredict_count;
    assign w_recover        = update_valid & update_mispredict;

    generate
        if (GHR_WIDTH == 1) begin : g_ghr_one
            assign w_ghr_shift   = pred_taken;
            assign w_ghr_recover = update_taken;
        end else begin : g_ghr_multi
            assign w_ghr_shift   = {r_ghr[GHR_WIDTH-2:0], pred_taken};
            assign w_ghr_recover = {update_ghr[GHR_WIDTH-2:0], update_taken};
        end
    endgenerate

    // High PC bits and the checkpoint MSB never influence the prediction.
    assign w_unused_bits = ^{lookup_pc, update_ghr};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_pht_size; i++) begin
                r_pht[i] <= c_ctr_init;
            end
            r_ghr              <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (update_valid) begin
                if (update_taken && (r_pht[update_index] != c_ctr_max)) begin
                    r_pht[update_index] <= r_pht[update_index] + CTR_WIDTH'(1);
                end else if (!update_taken && (r_pht[update_index] != '0)) begin
                    r_pht[update_index] <= r_pht[update_index] - CTR_WIDTH'(1);
                end
            end

            // A resolved mispredict discards any same-cycle speculative shift.
            if (w_recover) begin
                r_ghr <= w_ghr_recover;
            end else if (lookup_valid) begin
                r_ghr <= w_ghr_shift;
            end

            if (w_recover && (r_mispredict_count != 32'hFFFF_FFFF)) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_predictor
// Brief    : Self-checking bench for gshare_predictor: directed vector table,
//            reset-priority sequence, and random traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_predictor;

    logic        clk;
    logic        rst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [5:0]  pred_index;
    logic [5:0]  pred_ghr;
    logic        update_valid;
    logic [5:0]  update_index;
    logic        update_taken;
    logic        update_mispredict;
    logic [5:0]  update_ghr;
    logic [31:0] mispredict_count;

    int errors = 0;
    int checks = 0;

    gshare_predictor #(
        .PC_WIDTH (32),
        .PHT_WIDTH(6),
        .GHR_WIDTH(6),
        .CTR_WIDTH(2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .pred_taken       (pred_taken),
        .pred_index       (pred_index),
        .pred_ghr         (pred_ghr),
        .update_valid     (update_valid),
        .update_index     (update_index),
        .update_taken     (update_taken),
        .update_mispredict(update_mispredict),
        .update_ghr       (update_ghr),
        .mispredict_count (mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_in;
        logic        lv;
        logic [31:0] pc;
        logic        uv;
        logic [5:0]  uidx;
        logic        ut;
        logic        um;
        logic [5:0]  ughr;
        logic        e_taken;
        logic [5:0]  e_idx;
        logic [5:0]  e_ghr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: counters as integers 0..3, history as an integer 0..63.
    int     m_ctr [64];
    int     m_ghr;
    longint m_cnt;

    function automatic int m_index(input logic [31:0] pc);
        return ((int'(pc >> 2)) ^ m_ghr) % 64;
    endfunction

    task automatic m_step();
        int pt;
        if (rst) begin
            for (int i = 0; i < 64; i++) m_ctr[i] = 1;
            m_ghr = 0;
            m_cnt = 0;
        end else begin
            pt = (m_ctr[m_index(lookup_pc)] >= 2) ? 1 : 0;
            if (update_valid) begin
                if (update_taken) m_ctr[update_index] = (m_ctr[update_index] < 3) ? m_ctr[update_index] + 1 : 3;
                else              m_ctr[update_index] = (m_ctr[update_index] > 0) ? m_ctr[update_index] - 1 : 0;
            end
            if (update_valid && update_mispredict) begin
                m_ghr = (int'(update_ghr) * 2 + int'(update_taken)) % 64;
                m_cnt = (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
            end else if (lookup_valid) begin
                m_ghr = (m_ghr * 2 + pt) % 64;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst               = v.rst_in;
        lookup_valid      = v.lv;
        lookup_pc         = v.pc;
        update_valid      = v.uv;
        update_index      = v.uidx;
        update_taken      = v.ut;
        update_mispredict = v.um;
        update_ghr        = v.ughr;
        #1;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        m_step();
        #1;
    endtask

    function automatic vec_t mk(input logic lv, input logic [31:0] pc, input logic uv,
                                input logic [5:0] uidx, input logic ut, input logic um,
                                input logic [5:0] ughr, input logic e_taken,
                                input logic [5:0] e_idx, input logic [5:0] e_ghr,
                                input logic [31:0] e_cnt);
        vec_t v;
        v.rst_in = 1'b0; v.lv = lv; v.pc = pc; v.uv = uv; v.uidx = uidx; v.ut = ut;
        v.um = um; v.ughr = ughr; v.e_taken = e_taken; v.e_idx = e_idx;
        v.e_ghr = e_ghr; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        vec_t v;
        //              lv  pc            uv  uidx ut  um  ughr   taken idx ghr  cnt
        vecs.push_back(mk(1, 32'h104,      0,  0,   0,  0,  6'h00, 0,    1,  0,   0));
        vecs.push_back(mk(0, 32'h14,       1,  5,   1,  0,  6'h00, 0,    5,  0,   0));
        vecs.push_back(mk(0, 32'h14,       1,  5,   1,  0,  6'h00, 1,    5,  0,   0));
        vecs.push_back(mk(0, 32'h14,       0,  0,   0,  0,  6'h00, 1,    5,  0,   0));
        vecs.push_back(mk(0, 32'h14,       1,  5,   1,  0,  6'h00, 1,    5,  0,   0));
        vecs.push_back(mk(0, 32'h14,       1,  5,   0,  0,  6'h00, 1,    5,  0,   0));
        vecs.push_back(mk(0, 32'h14,       0,  0,   0,  0,  6'h00, 1,    5,  0,   0));
        vecs.push_back(mk(1, 32'h14,       1,  5,   1,  0,  6'h00, 1,    5,  0,   0));
        vecs.push_back(mk(0, 32'h14,       0,  0,   0,  0,  6'h00, 0,    4,  1,   0));
        vecs.push_back(mk(1, 32'h14,       1,  9,   1,  1,  6'h2A, 0,    4,  1,   0));
        vecs.push_back(mk(0, 32'h0,        0,  0,   0,  0,  6'h00, 0,    21, 6'h15, 1));
        vecs.push_back(mk(0, 32'h0,        0,  0,   1,  1,  6'h3F, 0,    21, 6'h15, 1));
        vecs.push_back(mk(0, 32'h0,        0,  0,   0,  0,  6'h00, 0,    21, 6'h15, 1));
        vecs.push_back(mk(0, 32'h58,       1,  3,   1,  0,  6'h00, 0,    3,  6'h15, 1));
        vecs.push_back(mk(0, 32'h58,       0,  0,   0,  0,  6'h00, 1,    3,  6'h15, 1));
        vecs.push_back(mk(1, 32'h58,       1,  3,   0,  1,  6'h01, 1,    3,  6'h15, 1));
        vecs.push_back(mk(0, 32'h58,       0,  0,   0,  0,  6'h00, 0,    20, 2,   2));
        vecs.push_back(mk(1, 32'h58,       0,  0,   0,  0,  6'h00, 0,    20, 2,   2));
        vecs.push_back(mk(0, 32'h0,        0,  0,   0,  0,  6'h00, 0,    4,  4,   2));
        vecs.push_back(mk(0, 32'hFFFF_FFFC,0,  0,   0,  0,  6'h00, 0,    59, 4,   2));

        rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0; update_valid = 1'b0;
        update_index = '0; update_taken = 1'b0; update_mispredict = 1'b0; update_ghr = '0;

        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.rst_in = 1'b1;
        repeat (2) begin
            drive(v);
            finish_cycle();
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            chk($sformatf("vec%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_taken));
            chk($sformatf("vec%0d pred_index", i), 32'(pred_index), 32'(vecs[i].e_idx));
            chk($sformatf("vec%0d pred_ghr", i),   32'(pred_ghr),   32'(vecs[i].e_ghr));
            chk($sformatf("vec%0d count", i),      mispredict_count, vecs[i].e_cnt);
            finish_cycle();
        end

        // Reset asserted alongside a lookup and a mispredicting update: none may stick.
        v = mk(1, 32'h14, 1, 5, 1, 1, 6'h3F, 0, 0, 0, 0);
        v.rst_in = 1'b1;
        drive(v);
        finish_cycle();

        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        chk("post-rst ghr", 32'(pred_ghr), 32'd0);
        chk("post-rst count", mispredict_count, 32'd0);
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 32'(i) << 2;
            #1;
            chk($sformatf("post-rst idx%0d taken", i), 32'(pred_taken), 32'd0);
            chk($sformatf("post-rst idx%0d index", i), 32'(pred_index), 32'(i));
        end
        finish_cycle();

        v = mk(0, 32'h14, 1, 5, 1, 0, 6'h00, 0, 0, 0, 0);
        drive(v);
        chk("post-rst ctr5 first", 32'(pred_taken), 32'd0);
        finish_cycle();
        v = mk(0, 32'h14, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0);
        drive(v);
        chk("post-rst ctr5 after one taken", 32'(pred_taken), 32'd1);
        finish_cycle();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            v.rst_in = ($urandom_range(0, 199) == 0);
            v.lv     = $urandom_range(0, 1);
            v.pc     = $urandom;
            v.uv     = $urandom_range(0, 1);
            v.uidx   = 6'($urandom);
            v.ut     = $urandom_range(0, 1);
            v.um     = ($urandom_range(0, 3) == 0);
            v.ughr   = 6'($urandom);
            drive(v);
            chk("rnd pred_taken", 32'(pred_taken), 32'((m_ctr[m_index(lookup_pc)] >= 2) ? 1 : 0));
            chk("rnd pred_index", 32'(pred_index), 32'(m_index(lookup_pc)));
            chk("rnd pred_ghr",   32'(pred_ghr),   32'(m_ghr));
            chk("rnd count",      mispredict_count, 32'(m_cnt));
            finish_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL provide parameter PC_WIDTH, default 32: width of the lookup PC.
REQ-002 SHALL provide parameter PHT_WIDTH, default 6: log2 of the counter-table depth (PHT_SIZE = 2^PHT_WIDTH).
REQ-003 SHALL provide parameter GHR_WIDTH, default 6: global history length; legal range 1..PHT_WIDTH.
REQ-004 SHALL provide parameter CTR_WIDTH, default 2: saturating counter width; legal range 2..4.
REQ-005 SHALL provide port clk  in  1  clock; all state changes on its rising edge.
REQ-006 SHALL provide port rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL provide port lookup_valid  in  1  conditional-branch lookup this cycle.
REQ-008 SHALL provide port lookup_pc  in  PC_WIDTH  branch PC.
REQ-009 SHALL provide port pred_taken  out  1  predicted direction.
REQ-010 SHALL provide port pred_index  out  PHT_WIDTH  table index used; carried down the pipe for update.
REQ-011 SHALL provide port pred_ghr  out  GHR_WIDTH  GHR value before this lookup's speculative shift; carried as a recovery checkpoint.
REQ-012 SHALL provide port update_valid  in  1  resolved conditional branch this cycle.
REQ-013 SHALL provide port update_index  in  PHT_WIDTH  pred_index returned from the lookup.
REQ-014 SHALL provide port update_taken  in  1  actual direction.
REQ-015 SHALL provide port update_mispredict  in  1  resolved direction differed from the prediction.
REQ-016 SHALL provide port update_ghr  in  GHR_WIDTH  pred_ghr returned from the lookup.
REQ-017 SHALL provide port mispredict_count  out  32  saturating count of accepted mispredicts.

Function
REQ-018 SHALL compute index = lookup_pc[PHT_WIDTH+1:2] XOR zero-extended GHR, combinationally.
REQ-019 SHALL drive pred_taken = MSB of counter[index], pred_index = index, and pred_ghr = current GHR, combinationally and independent of lookup_valid.
REQ-020 SHALL, on update_valid, increment counter[update_index] if update_taken and not all-ones, decrement it if not update_taken and not zero, and otherwise leave it unchanged.
REQ-021 SHALL NOT bypass: a lookup in the same cycle as an update to the same index sees the pre-update counter; the new value is visible the next cycle.
REQ-022 SHALL, on lookup_valid without an accepted mispredict, shift the GHR left by one bit, inserting pred_taken at bit 0 and discarding the MSB.
REQ-023 SHALL, on update_valid && update_mispredict, load GHR <= {update_ghr[GHR_WIDTH-2:0], update_taken}; for GHR_WIDTH=1, GHR <= update_taken.
REQ-024 SHALL give mispredict recovery priority over a same-cycle lookup; that lookup's speculative shift is discarded, but its combinational outputs remain as specified.
REQ-025 SHALL ignore update_mispredict when update_valid is 0.
REQ-026 SHALL increment mispredict_count on each accepted mispredict, saturating at 0xFFFFFFFF.
REQ-027 SHALL wrap the index modulo PHT_SIZE; there is no out-of-range index.

Reset
REQ-028 SHALL, while rst is high at a clock edge, set all PHT_SIZE counters to weakly-not-taken (MSB 0, all other bits 1; 2'b01 for CTR_WIDTH=2), GHR to 0, and mispredict_count to 0.
REQ-029 SHALL give rst priority over all same-cycle lookups and updates; none take effect.
REQ-030 SHALL, after reset with GHR=0, drive pred_taken=0 for every lookup_pc.

Verification
REQ-031 Reset, then lookup_pc=0x104 -> pred_index=1, pred_taken=0, pred_ghr=0; after lookup_valid, GHR stays 0 because the prediction was not-taken.
REQ-032 Two updates to index 5 with taken=1 -> counter 01->10->11; lookup_pc=0x14 -> pred_taken=1; a third taken update stays 11; one not-taken update gives 10, pred_taken still 1.
REQ-033 With counter[5]=11 and GHR=0, lookup_valid and lookup_pc=0x14 -> next cycle GHR=6'b000001; lookup_pc=0x14 then gives pred_index=4.
REQ-034 Same-cycle lookup_valid plus update_valid, update_mispredict=1, update_ghr=6'b101010, update_taken=1 -> next GHR=6'b010101 and mispredict_count incremented by 1.
REQ-035 Train several counters, set GHR nonzero, then assert rst concurrently with update_valid -> all counters 01, GHR=0, mispredict_count=0; the update is not applied.
REQ-036 Same-cycle update (taken) and lookup to index 3 from 01 -> lookup returns pred_taken=0; the next-cycle lookup returns 1.
